// File: rtl/pcie_dma_desc_mux.sv
// pcie_dma_desc_mux: round-robin share of one DMA descriptor channel between PORTS requesters.
// Ports: clk/rst (sync, active-high); s_axis_desc_* per-port descriptors (port i at slice i) with
// combinational one-hot ready; m_axis_desc_* registered descriptor to the DMA, tag = {port, s_tag};
// s_axis_desc_status_* status from the DMA; m_axis_desc_status_* status routed back by tag prefix
// (one-hot valid, shared tag); enable gates new grants; status_error pulses on unroutable status.
module pcie_dma_desc_mux #(
    parameter int PORTS           = 4,
    parameter int PCIE_ADDR_WIDTH = 64,
    parameter int AXI_ADDR_WIDTH  = 64,
    parameter int LEN_WIDTH       = 20,
    parameter int S_TAG_WIDTH     = 6,
    parameter int M_TAG_WIDTH     = S_TAG_WIDTH + $clog2(PORTS),
    parameter int MAX_OUTSTANDING = 16
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [PORTS*PCIE_ADDR_WIDTH-1:0] s_axis_desc_pcie_addr,
    input  logic [PORTS*AXI_ADDR_WIDTH-1:0]  s_axis_desc_axi_addr,
    input  logic [PORTS*LEN_WIDTH-1:0]       s_axis_desc_len,
    input  logic [PORTS*S_TAG_WIDTH-1:0]     s_axis_desc_tag,
    input  logic [PORTS-1:0]                 s_axis_desc_valid,
    output logic [PORTS-1:0]                 s_axis_desc_ready,
    output logic [PCIE_ADDR_WIDTH-1:0]       m_axis_desc_pcie_addr,
    output logic [AXI_ADDR_WIDTH-1:0]        m_axis_desc_axi_addr,
    output logic [LEN_WIDTH-1:0]             m_axis_desc_len,
    output logic [M_TAG_WIDTH-1:0]           m_axis_desc_tag,
    output logic                             m_axis_desc_valid,
    input  logic                             m_axis_desc_ready,
    input  logic [M_TAG_WIDTH-1:0]           s_axis_desc_status_tag,
    input  logic                             s_axis_desc_status_valid,
    output logic [S_TAG_WIDTH-1:0]           m_axis_desc_status_tag,
    output logic [PORTS-1:0]                 m_axis_desc_status_valid,
    input  logic                             enable,
    output logic                             status_error
);
    localparam int PW = $clog2(PORTS);
    localparam int CW = $clog2(MAX_OUTSTANDING + 1);
    logic [CW-1:0]              r_cnt [PORTS];
    logic [PW-1:0]              r_ptr;
    logic                       r_valid;
    logic [PCIE_ADDR_WIDTH-1:0] r_pcie_addr;
    logic [AXI_ADDR_WIDTH-1:0]  r_axi_addr;
    logic [LEN_WIDTH-1:0]       r_len;
    logic [M_TAG_WIDTH-1:0]     r_tag;
    logic [PORTS-1:0]           r_st_valid;
    logic [S_TAG_WIDTH-1:0]     r_st_tag;
    logic                       r_err;
    logic [PW-1:0]              w_sidx;
    logic                       w_sok;
    logic [PORTS-1:0]           w_dec;
    logic [PORTS-1:0]           w_elig;
    logic [PORTS-1:0]           w_grant;
    logic [PW-1:0]              w_sel;
    logic [PW-1:0]              w_c;
    logic                       w_hit;
    logic                       w_any;
    assign w_sidx = s_axis_desc_status_tag[M_TAG_WIDTH-1 -: PW];
    assign w_sok  = s_axis_desc_status_valid && (int'(w_sidx) < PORTS) && (r_cnt[w_sidx] != '0);
    // a status arriving this cycle already frees its slot, so a port at the limit can win now
    always_comb begin
        w_dec  = '0;
        w_elig = '0;
        for (int i = 0; i < PORTS; i++) begin
            w_dec[i]  = w_sok && (int'(w_sidx) == i);
            w_elig[i] = s_axis_desc_valid[i] && enable &&
                        ((r_cnt[i] - CW'(w_dec[i])) < CW'(MAX_OUTSTANDING));
        end
    end
    always_comb begin
        w_sel = '0;
        w_hit = 1'b0;
        w_c   = '0;
        for (int j = 0; j < PORTS; j++) begin
            w_c = PW'((int'(r_ptr) + j) % PORTS);
            if (!w_hit && w_elig[w_c]) begin
                w_hit = 1'b1;
                w_sel = w_c;
            end
        end
        w_any   = w_hit && !rst && (!r_valid || m_axis_desc_ready);
        w_grant = w_any ? (PORTS'(1) << w_sel) : '0;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid     <= 1'b0;
            r_pcie_addr <= '0;
            r_axi_addr  <= '0;
            r_len       <= '0;
            r_tag       <= '0;
            r_ptr       <= '0;
            r_st_valid  <= '0;
            r_st_tag    <= '0;
            r_err       <= 1'b0;
            for (int i = 0; i < PORTS; i++) r_cnt[i] <= '0;
        end else begin
            if (w_any) begin
                r_valid     <= 1'b1;
                r_pcie_addr <= s_axis_desc_pcie_addr[w_sel*PCIE_ADDR_WIDTH +: PCIE_ADDR_WIDTH];
                r_axi_addr  <= s_axis_desc_axi_addr[w_sel*AXI_ADDR_WIDTH +: AXI_ADDR_WIDTH];
                r_len       <= s_axis_desc_len[w_sel*LEN_WIDTH +: LEN_WIDTH];
                r_tag       <= {w_sel, s_axis_desc_tag[w_sel*S_TAG_WIDTH +: S_TAG_WIDTH]};
                r_ptr       <= PW'((int'(w_sel) + 1) % PORTS);
            end else if (m_axis_desc_ready) begin
                r_valid <= 1'b0;
            end
            r_st_valid <= w_dec;
            r_err      <= s_axis_desc_status_valid && !w_sok;
            if (w_sok) r_st_tag <= s_axis_desc_status_tag[S_TAG_WIDTH-1:0];
            for (int i = 0; i < PORTS; i++) r_cnt[i] <= r_cnt[i] + CW'(w_grant[i]) - CW'(w_dec[i]);
        end
    end
    assign s_axis_desc_ready        = w_grant;
    assign m_axis_desc_valid        = r_valid;
    assign m_axis_desc_pcie_addr    = r_pcie_addr;
    assign m_axis_desc_axi_addr     = r_axi_addr;
    assign m_axis_desc_len          = r_len;
    assign m_axis_desc_tag          = r_tag;
    assign m_axis_desc_status_valid = r_st_valid;
    assign m_axis_desc_status_tag   = r_st_tag;
    assign status_error             = r_err;
endmodule
